// File: rtl/pwm_multi_fade_if.sv
// Control and LED-side signal bundle for pwm_multi_fade.
// The board controller owns the master side; the PWM block owns the slave side.
interface pwm_multi_fade_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CH_W     = 3
);

  logic                en;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [CNT_W-1:0]    wr_duty;
  logic [CHANNELS-1:0] breathe;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;

  modport master (
    output en,
    output wr_en,
    output wr_ch,
    output wr_duty,
    output breathe,
    input  pwm_out,
    input  period_start
  );

  modport slave (
    input  en,
    input  wr_en,
    input  wr_ch,
    input  wr_duty,
    input  breathe,
    output pwm_out,
    output period_start
  );

endinterface

// File: rtl/pwm_multi_fade.sv
// N-channel LED PWM with a shared period counter, double-buffered duties and
// an optional per-channel breathe ramp that steps every RAMP_DIV periods.
module pwm_multi_fade #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned PWM_FREQ  = 1_250,
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CH_W      = 3,
  parameter int unsigned RAMP_DIV  = 10,
  parameter int unsigned RAMP_STEP = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_multi_fade_if.slave   bus
);

  localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned EXT_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0]  PERIOD_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  STEP_C    = CNT_W'(RAMP_STEP);
  localparam logic [EXT_W-1:0]  PERIOD_X  = EXT_W'(PERIOD);
  localparam logic [EXT_W-1:0]  STEP_X    = EXT_W'(RAMP_STEP);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0]    cnt;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic [CNT_W-1:0]    pending [CHANNELS];
  logic [CNT_W-1:0]    active  [CHANNELS];
  logic [CNT_W-1:0]    level   [CHANNELS];
  logic [CHANNELS-1:0] dir_down;
  logic [CHANNELS-1:0] pwm_q;
  logic                period_start_q;

  logic                boundary_c;
  logic                ramp_step_c;
  logic                wr_hit_c;
  logic [CNT_W-1:0]    wr_clamp_c;
  logic [CNT_W-1:0]    level_nxt_c [CHANNELS];
  logic [CHANNELS-1:0] dir_down_nxt_c;

  assign boundary_c  = bus.en && (cnt == LAST_C);
  assign ramp_step_c = boundary_c && (ramp_cnt == RAMP_LAST);
  assign wr_hit_c    = bus.wr_en && (32'(bus.wr_ch) < CHANNELS);
  assign wr_clamp_c  = (bus.wr_duty > PERIOD_C) ? PERIOD_C : bus.wr_duty;

  // Triangle-wave step, evaluated in CNT_W+1 bits so the up-ramp cannot wrap.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      level_nxt_c[i]    = level[i];
      dir_down_nxt_c[i] = dir_down[i];
      if (!dir_down[i]) begin
        if (({1'b0, level[i]} + STEP_X) >= PERIOD_X) begin
          level_nxt_c[i]    = PERIOD_C;
          dir_down_nxt_c[i] = 1'b1;
        end else begin
          level_nxt_c[i] = level[i] + STEP_C;
        end
      end else begin
        if ({1'b0, level[i]} <= STEP_X) begin
          level_nxt_c[i]    = '0;
          dir_down_nxt_c[i] = 1'b0;
        end else begin
          level_nxt_c[i] = level[i] - STEP_C;
        end
      end
    end
  end

  // Shared period counter and breathe prescaler; both park at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ramp_cnt <= '0;
    end else if (!bus.en) begin
      cnt      <= '0;
      ramp_cnt <= '0;
    end else begin
      cnt <= boundary_c ? '0 : cnt + CNT_W'(1);
      if (boundary_c) begin
        ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_W'(1);
      end
    end
  end

  // Shadow/active duty registers; active only moves at a boundary while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
        level[i]   <= '0;
      end
      dir_down <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (wr_hit_c && (bus.wr_ch == CH_W'(i))) begin
          pending[i] <= wr_clamp_c;
        end
        if (!bus.en) begin
          active[i]   <= pending[i];
          level[i]    <= '0;
          dir_down[i] <= 1'b0;
        end else if (boundary_c) begin
          if (bus.breathe[i]) begin
            if (ramp_step_c) begin
              level[i]    <= level_nxt_c[i];
              dir_down[i] <= dir_down_nxt_c[i];
              active[i]   <= level_nxt_c[i];
            end else begin
              active[i] <= level[i];
            end
          end else begin
            active[i] <= pending[i];
          end
        end
      end
    end
  end

  // Output stage: one cycle behind cnt so each period's high run starts with period_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= bus.en && (cnt == '0);
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pwm_q[i] <= bus.en && (cnt < active[i]);
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;

endmodule
